// File: rtl/triloc.sv
// Sequential trilateration estimator: three range-weighted pair points summed (3x location).
// One shared serial restoring divider, one quotient bit per cycle, six divisions per run.
module triloc #(
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic signed [N-1:0] xA,
   input  logic signed [N-1:0] yA,
   input  logic signed [N-1:0] xB,
   input  logic signed [N-1:0] yB,
   input  logic signed [N-1:0] xC,
   input  logic signed [N-1:0] yC,
   input  logic        [N:0]   rA,
   input  logic        [N:0]   rB,
   input  logic        [N:0]   rC,
   output logic                busy,
   output logic                done,
   output logic signed [N+3:0] xM,
   output logic signed [N+3:0] yM,
   output logic        [1:0]   o_dbg_state
);

   localparam int CW = $clog2(2*N+2);
   localparam logic [CW-1:0] LAST = CW'(2*N+1);

   typedef enum logic [1:0] {IDLE, DIV, ACC, SUM} state_t;
   state_t r_state, w_state_nxt;

   logic signed [N-1:0] r_xa, r_ya, r_xb, r_yb, r_xc, r_yc;
   logic        [N:0]   r_ra, r_rb, r_rc;
   logic        [2:0]   r_div;
   logic        [CW-1:0] r_cnt;
   logic        [N+1:0] r_rem;
   logic        [2*N+1:0] r_quo;
   logic signed [N+1:0] r_pt;
   logic                r_pt_vld, r_pt_y;
   logic signed [N+3:0] r_acc_x, r_acc_y;

   logic signed [N-1:0] w_p, w_q;
   logic        [N:0]   w_rp, w_rq;
   logic signed [N:0]   w_d;
   logic                w_neg, w_ge;
   logic        [N:0]   w_mag;
   logic        [N+1:0] w_den, w_rin, w_rem_nxt, w_qm, w_qs;
   logic        [2*N+1:0] w_prod, w_num, w_quo_nxt;
   logic        [N+2:0] w_trial;
   logic signed [N+1:0] w_pt;

   // Operand select: r_div[2:1] is the pair (AB, BC, CA), r_div[0] the axis (x, y).
   always_comb begin
      w_p  = '0;
      w_q  = '0;
      w_rp = '0;
      w_rq = '0;
      case (r_div[2:1])
         2'd0: begin
            w_p = r_div[0] ? r_ya : r_xa;  w_q = r_div[0] ? r_yb : r_xb;
            w_rp = r_ra;  w_rq = r_rb;
         end
         2'd1: begin
            w_p = r_div[0] ? r_yb : r_xb;  w_q = r_div[0] ? r_yc : r_xc;
            w_rp = r_rb;  w_rq = r_rc;
         end
         default: begin
            w_p = r_div[0] ? r_yc : r_xc;  w_q = r_div[0] ? r_ya : r_xa;
            w_rp = r_rc;  w_rq = r_ra;
         end
      endcase
   end

   assign w_d    = {w_q[N-1], w_q} - {w_p[N-1], w_p};
   assign w_neg  = w_d[N];
   assign w_mag  = w_neg ? -w_d : w_d;
   assign w_den  = {1'b0, w_rp} + {1'b0, w_rq};
   assign w_prod = {{(N+1){1'b0}}, w_mag} * {{(N+1){1'b0}}, w_rp};

   // Restoring step; the first step of each division takes the fresh product directly.
   assign w_num     = (r_cnt == '0) ? w_prod : r_quo;
   assign w_rin     = (r_cnt == '0) ? '0 : r_rem;
   assign w_trial   = {w_rin, w_num[2*N+1]} - {1'b0, w_den};
   assign w_ge      = ~w_trial[N+2];
   assign w_rem_nxt = w_ge ? w_trial[N+1:0] : {w_rin[N:0], w_num[2*N+1]};
   assign w_quo_nxt = {w_num[2*N:0], w_ge};

   // |q| <= |d| so the low N+2 bits hold the whole magnitude; zero divisor forces q=0.
   assign w_qm = w_quo_nxt[N+1:0];
   assign w_qs = (w_den == '0) ? '0 : (w_neg ? -w_qm : w_qm);
   assign w_pt = {{2{w_p[N-1]}}, w_p} + w_qs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = DIV;
         DIV:  if (r_cnt == LAST && r_div == 3'd5) w_state_nxt = ACC;
         ACC:  w_state_nxt = SUM;
         SUM:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xa <= '0; r_ya <= '0; r_xb <= '0; r_yb <= '0; r_xc <= '0; r_yc <= '0;
         r_ra <= '0; r_rb <= '0; r_rc <= '0;
         r_div <= '0; r_cnt <= '0; r_rem <= '0; r_quo <= '0;
         r_pt <= '0; r_pt_vld <= 1'b0; r_pt_y <= 1'b0;
         r_acc_x <= '0; r_acc_y <= '0;
         busy <= 1'b0; done <= 1'b0; xM <= '0; yM <= '0;
      end else begin
         done     <= (r_state == SUM);
         r_pt_vld <= (r_state == DIV) && (r_cnt == LAST);
         if (r_state == IDLE && start) begin
            r_xa <= xA; r_ya <= yA; r_xb <= xB; r_yb <= yB; r_xc <= xC; r_yc <= yC;
            r_ra <= rA; r_rb <= rB; r_rc <= rC;
            r_div <= '0; r_cnt <= '0;
            r_acc_x <= '0; r_acc_y <= '0;
            busy <= 1'b1;
         end else if (r_pt_vld) begin
            if (r_pt_y) r_acc_y <= r_acc_y + {{2{r_pt[N+1]}}, r_pt};
            else        r_acc_x <= r_acc_x + {{2{r_pt[N+1]}}, r_pt};
         end
         if (r_state == DIV) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == LAST) begin
               r_cnt  <= '0;
               r_div  <= r_div + 3'd1;
               r_pt   <= w_pt;
               r_pt_y <= r_div[0];
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         if (r_state == SUM) begin
            xM   <= r_acc_x;
            yM   <= r_acc_y;
            busy <= 1'b0;
         end
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_triloc.sv
// Bench for triloc: directed vectors, handshake and reset cases, then random runs vs an integer model.
module tb_triloc;
   localparam int N = 8;
   localparam int LAT = 6*(2*N+2)+2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic signed [N-1:0] xA = '0, yA = '0, xB = '0, yB = '0, xC = '0, yC = '0;
   logic [N:0] rA = '0, rB = '0, rC = '0;
   logic busy, done;
   logic signed [N+3:0] xM, yM;
   logic [1:0] dbg_state;

   int total = 0;
   int bad = 0;
   int last_x, last_y;

   always #5 clk = ~clk;

   triloc #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .xA(xA), .yA(yA), .xB(xB), .yB(yB), .xC(xC), .yC(yC),
      .rA(rA), .rB(rB), .rC(rC),
      .busy(busy), .done(done), .xM(xM), .yM(yM), .o_dbg_state(dbg_state)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pair point straight from the definition: P + trunc((Q-P)*rP/(rP+rQ)).
   function automatic int pt(input int p, input int q, input int rp, input int rq);
      if (rp + rq == 0) return p;
      return p + ((q - p) * rp) / (rp + rq);
   endfunction

   task automatic set_in(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int ra, input int rb, input int rc);
      xA = N'(ax); yA = N'(ay); xB = N'(bx); yB = N'(by); xC = N'(cx); yC = N'(cy);
      rA = (N+1)'(ra); rB = (N+1)'(rb); rC = (N+1)'(rc);
   endtask

   task automatic scramble();
      set_in($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
             $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
             $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
             $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
   endtask

   // Called at a negedge with inputs set; returns one negedge after the done edge.
   task automatic run(input string tag, input bit restart);
      int ex, ey, done_cnt, done_edge, busy_err;
      ex = pt(int'(xA), int'(xB), int'(rA), int'(rB)) + pt(int'(xB), int'(xC), int'(rB), int'(rC))
         + pt(int'(xC), int'(xA), int'(rC), int'(rA));
      ey = pt(int'(yA), int'(yB), int'(rA), int'(rB)) + pt(int'(yB), int'(yC), int'(rB), int'(rC))
         + pt(int'(yC), int'(yA), int'(rC), int'(rA));
      done_cnt = 0; done_edge = -1; busy_err = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      scramble();
      for (int e = 1; e <= LAT; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_cnt++;
            if (done_edge < 0) done_edge = e;
         end
         if (busy !== (e < LAT)) busy_err++;
         if (restart && e == 4) begin
            start = 1'b1;
            scramble();
         end
         if (restart && e == 5) start = 1'b0;
      end
      check({tag, " done_edge"}, done_edge, LAT);
      check({tag, " done_cnt"}, done_cnt, 1);
      check({tag, " busy_err"}, busy_err, 0);
      check({tag, " xM"}, int'(xM), ex);
      check({tag, " yM"}, int'(yM), ey);
      last_x = ex; last_y = ey;
      @(negedge clk);
   endtask

   initial begin
      int dcnt, berr;
      repeat (3) @(negedge clk);
      check("reset xM", int'(xM), 0);
      check("reset yM", int'(yM), 0);
      check("reset done", int'(done), 0);
      check("reset busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      set_in(-16, -111, 109, -99, -32, 108, 236, 183, 215);
      run("ref", 1'b0);
      check("ref xM const", int'(xM), 74);
      check("ref yM const", int'(yM), -105);

      set_in(0, 0, 10, 0, 0, 10, 5, 5, 5);
      run("sym", 1'b0);
      check("sym xM const", int'(xM), 10);

      set_in(3, -4, -7, 2, 1, 1, 0, 0, 0);
      run("zero", 1'b0);
      check("zero yM const", int'(yM), -1);

      set_in(-128, -128, 127, 127, -128, 127, 0, 511, 0);
      run("ext", 1'b0);
      check("ext xM const", int'(xM), -384);
      check("ext yM const", int'(yM), 126);

      // Restart pulse mid-run is ignored; next run starts the cycle after done.
      set_in(40, -20, -60, 90, 15, 15, 100, 300, 7);
      run("hs1", 1'b1);
      set_in(-5, 77, 33, -33, 120, -100, 450, 12, 260);
      run("hs2", 1'b0);

      repeat (20) @(negedge clk);
      check("hold xM", int'(xM), last_x);
      check("hold yM", int'(yM), last_y);

      // Reset at edge 50 of a run.
      set_in(11, 22, 33, 44, 55, 66, 77, 88, 99);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (50) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort xM", int'(xM), 0);
      check("abort yM", int'(yM), 0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0; berr = 0;
      for (int e = 0; e < 130; e++) begin
         @(posedge clk);
         #1;
         if (done) dcnt++;
         if (busy) berr++;
      end
      check("abort no_done", dcnt, 0);
      check("abort no_busy", berr, 0);
      @(negedge clk);
      set_in(-16, -111, 109, -99, -32, 108, 236, 183, 215);
      run("post_rst", 1'b0);

      for (int k = 0; k < 16; k++) begin
         scramble();
         if (k % 4 == 1) rA = '0;
         if (k % 4 == 2) begin rB = '0; rC = '0; end
         if (k % 8 == 3) set_in(-128, 127, 127, -128, -128, -128, 511, 511, 511);
         run($sformatf("rnd%0d", k), k % 5 == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
